// File: rtl/sdram_byte_unpacker.sv
// SDRAM word-to-byte unpacker: a small word FIFO feeding a one-word output stage
// that emits two bytes per word over valid/ready, with per-job counting.
module sdram_byte_unpacker #(
    parameter int FIFO_DEPTH    = 4,
    parameter bit LITTLE_ENDIAN = 1'b1,
    parameter int COUNT_W       = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] num_words,
    input  logic               word_valid,
    input  logic [15:0]        word_data,
    output logic               word_ready,
    output logic               byte_valid,
    output logic [7:0]         byte_data,
    input  logic               byte_ready,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W:0]   byte_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
    localparam logic [COUNT_W-1:0] WORD_ONE = COUNT_W'(1);
    localparam logic [COUNT_W:0]   BYTE_ONE = (COUNT_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [15:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        fifo_cnt;
    logic               fifo_empty, fifo_full;

    logic [15:0]        out_word;
    logic               out_idx;
    logic               out_valid;

    logic [COUNT_W-1:0] num_words_q;
    logic [COUNT_W-1:0] words_accepted;

    logic push, pop, load, byte_fire, start_accept, last_word, last_byte;

    assign fifo_empty   = (fifo_cnt == '0);
    assign fifo_full    = (fifo_cnt == FULL_CNT);
    // Intake depends only on registered state, so byte_ready never reaches word_ready.
    assign word_ready   = (state == S_RUN) && !fifo_full && (words_accepted < num_words_q);
    assign push         = word_valid && word_ready;
    assign byte_fire    = out_valid && byte_ready;
    assign load         = !out_valid || (byte_fire && out_idx);
    assign pop          = load && !fifo_empty;
    assign start_accept = (state == S_IDLE) && start;
    assign last_word    = push && (words_accepted == num_words_q - WORD_ONE);
    assign last_byte    = byte_fire && out_idx && fifo_empty;

    assign byte_valid = out_valid;
    assign byte_data  = (out_idx == LITTLE_ENDIAN) ? out_word[15:8] : out_word[7:0];
    assign busy       = (state == S_RUN) || (state == S_DRAIN);
    assign done       = (state == S_DONE);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state logic for the job sequencer.
    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        unique case (state)
            S_IDLE:  if (start) next_state = (num_words != '0) ? S_RUN : S_DONE;
            S_RUN:   if (last_word) next_state = S_DRAIN;
            S_DRAIN: if (last_byte) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // FIFO storage array.
    always_ff @(posedge clk) begin
        // NOTE: storage is left unreset; pointers and count define validity, so contents never leak.
        if (push) mem[wr_ptr] <= word_data;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_ONE;
            else if (pop && !push) fifo_cnt <= fifo_cnt - CNT_ONE;
        end
    end

    // Output stage: holds one word and steps through its two bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_word  <= '0;
            out_idx   <= 1'b0;
            out_valid <= 1'b0;
        end else if (load) begin
            if (!fifo_empty) begin
                out_word  <= mem[rd_ptr];
                out_idx   <= 1'b0;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
                out_idx   <= 1'b0;
            end
        end else if (byte_fire) begin
            out_idx <= 1'b1;
        end
    end

    // Per-job word and byte counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            num_words_q    <= '0;
            words_accepted <= '0;
            byte_count     <= '0;
        end else if (start_accept) begin
            num_words_q    <= num_words;
            words_accepted <= '0;
            byte_count     <= '0;
        end else begin
            if (push)      words_accepted <= words_accepted + WORD_ONE;
            if (byte_fire) byte_count     <= byte_count + BYTE_ONE;
        end
    end

endmodule

// File: tb/tb_sdram_byte_unpacker.sv
// Directed bench for sdram_byte_unpacker: little- and big-endian instances share stimulus.
module tb_sdram_byte_unpacker;

    localparam int COUNT_W = 24;

    logic               clk = 1'b0;
    logic               reset, start, word_valid, byte_ready;
    logic [COUNT_W-1:0] num_words;
    logic [15:0]        word_data;
    logic               word_ready, byte_valid, busy, done;
    logic [7:0]         byte_data;
    logic [COUNT_W:0]   byte_count;
    logic               be_word_ready, be_byte_valid, be_busy, be_done;
    logic [7:0]         be_byte_data;
    logic [COUNT_W:0]   be_byte_count;

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] word_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_be_q[$];
    int sent, got, dones, cyc, first_cyc, last_cyc;

    always #5 clk = ~clk;

    sdram_byte_unpacker #(.FIFO_DEPTH(4), .LITTLE_ENDIAN(1'b1), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .busy(busy), .done(done), .byte_count(byte_count)
    );

    sdram_byte_unpacker #(.FIFO_DEPTH(4), .LITTLE_ENDIAN(1'b0), .COUNT_W(COUNT_W)) dut_be (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .word_valid(word_valid), .word_data(word_data), .word_ready(be_word_ready),
        .byte_valid(be_byte_valid), .byte_data(be_byte_data), .byte_ready(byte_ready),
        .busy(be_busy), .done(be_done), .byte_count(be_byte_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sb();
        word_q.delete(); exp_q.delete(); exp_be_q.delete();
        sent = 0; got = 0; dones = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
    endtask

    task automatic add_word(input logic [15:0] w);
        word_q.push_back(w);
        exp_q.push_back(w[7:0]);  exp_q.push_back(w[15:8]);
        exp_be_q.push_back(w[15:8]); exp_be_q.push_back(w[7:0]);
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        start = 1'b1; num_words = COUNT_W'(n); word_valid = 1'b0; byte_ready = 1'b1;
    endtask

    // mode 0: always valid/ready; 1: random; 2: upstream valid, downstream stalled.
    task automatic drive(input int n, input int mode, input int max_cycles,
                         input bit stop_on_done, input int stop_got);
        for (int k = 0; k < max_cycles; k++) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            byte_ready = (mode == 2) ? 1'b0 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < n && (mode != 1 || $urandom_range(0, 3) != 0)) begin
                word_valid = 1'b1; word_data = word_q[sent];
            end else begin
                word_valid = 1'b0;
            end
            if (done) dones++;
            if (stop_on_done && dones > 0) break;
            if (word_valid && word_ready) sent++;
            if (byte_valid && byte_ready) begin
                if (got < exp_q.size()) begin
                    check("byte_le", {24'h0, byte_data}, {24'h0, exp_q[got]});
                    check("byte_be", {24'h0, be_byte_data}, {24'h0, exp_be_q[got]});
                end else begin
                    check("byte_extra", got, exp_q.size());
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
                if (got == stop_got) break;
            end
        end
        word_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_words = '0; word_valid = 1'b0;
        word_data = '0; byte_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_word_ready", word_ready, 0);
        check("rst_byte_valid", byte_valid, 0);
        check("rst_byte_data", byte_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_byte_count", byte_count, 0);
        reset = 1'b0;

        // Test 1: three words at full rate.
        clear_sb();
        add_word(16'h0201); add_word(16'h0403); add_word(16'h0605);
        do_start(3);
        drive(3, 0, 100, 1'b1, -1);
        check("t1_bytes", got, 6);
        check("t1_consecutive", last_cyc - first_cyc, 5);
        check("t1_done_pulse", dones, 1);
        check("t1_busy_at_done", busy, 0);
        check("t1_byte_count", byte_count, 6);
        @(negedge clk);
        check("t1_done_low", done, 0);
        check("t1_count_hold", byte_count, 6);

        // Test 2: single word, both byte orders.
        clear_sb();
        add_word(16'hABCD);
        do_start(1);
        drive(1, 0, 50, 1'b1, -1);
        check("t2_bytes", got, 2);
        check("t2_be_count", be_byte_count, 2);

        // Test 3: stalled downstream fills FIFO plus output stage, then releases.
        clear_sb();
        for (int k = 0; k < 8; k++) add_word({8'(2*k+2), 8'(2*k+1)});
        do_start(8);
        drive(8, 2, 12, 1'b0, -1);
        check("t3_accepted", sent, 5);
        check("t3_word_ready_low", word_ready, 0);
        check("t3_byte_valid", byte_valid, 1);
        check("t3_byte_hold", byte_data, 8'h01);
        check("t3_be_byte_hold", be_byte_data, 8'h02);
        drive(8, 0, 200, 1'b1, -1);
        check("t3_bytes", got, 16);
        check("t3_done_pulse", dones, 1);
        check("t3_byte_count", byte_count, 16);

        // Test 4: zero-length job.
        clear_sb();
        do_start(0);
        check("t4_busy_pre", busy, 0);
        @(negedge clk);
        start = 1'b0;
        check("t4_done", done, 1);
        check("t4_busy", busy, 0);
        check("t4_byte_count", byte_count, 0);
        @(negedge clk);
        check("t4_done_low", done, 0);
        check("t4_busy_post", busy, 0);

        // Test 5: reset mid-job after three bytes, then a clean job.
        clear_sb();
        for (int k = 0; k < 8; k++) add_word(16'h1111 * 16'(k + 1));
        do_start(8);
        drive(8, 0, 100, 1'b0, 3);
        @(negedge clk);
        check("t5_pre_reset_count", byte_count, 3);
        reset = 1'b1;
        @(negedge clk);
        check("t5_word_ready", word_ready, 0);
        check("t5_byte_valid", byte_valid, 0);
        check("t5_byte_data", byte_data, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_byte_count", byte_count, 0);
        reset = 1'b0;
        @(negedge clk);
        check("t5_no_done", done, 0);
        clear_sb();
        add_word(16'h5A3C); add_word(16'hC3E1);
        do_start(2);
        drive(2, 0, 50, 1'b1, -1);
        check("t5_bytes", got, 4);
        check("t5_done_pulse", dones, 1);
        check("t5_byte_count", byte_count, 4);

        // Test 6: randomized handshakes over 1000 words.
        clear_sb();
        for (int k = 0; k < 1000; k++) add_word(16'($urandom));
        do_start(1000);
        drive(1000, 1, 20000, 1'b1, -1);
        check("t6_bytes", got, 2000);
        check("t6_done_pulse", dones, 1);
        check("t6_byte_count", byte_count, 2000);
        check("t6_be_byte_count", be_byte_count, 2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
